// File: rtl/score_submit_arbiter.sv
// score_submit_arbiter
//   Round-robin arbiter that shares one score tracker among up to five
//   player-side requesters. A grant drives a one-cycle enable pulse into the
//   tracker, then the arbiter waits a fixed busy window (the tracker has no
//   done signal) before acknowledging the requester. After reset it holds off
//   all traffic while the tracker clears its RAM.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset (shared with the tracker)
//   req            level request per player, held until the matching ack
//   score_in       packed 4-bit scores, player i at [4i+3:4i], sampled at grant
//   ack            one-hot, one-cycle completion pulse
//   trk_playerID   tracker playerID (held from grant to the next grant)
//   trk_newScore   tracker newScore, clamped to 7 (held like trk_playerID)
//   trk_enable     tracker enable, one-cycle pulse per grant
//   busy           high in every state except IDLE
//   last_grant     index of the most recently acknowledged player
//   dbg_state      current FSM state: 0 BOOT, 1 IDLE, 2 ISSUE, 3 HOLD, 4 ACK
//
// Handshake: req is a level request. A requester raises req[i] with a stable
// score and keeps it high until it sees ack[i] for one cycle. Dropping req
// early does not cancel a grant already made; holding req after ack simply
// re-enters arbitration at the lowest priority.
module score_submit_arbiter #(
  parameter int NUM_PLAYERS = 5,
  parameter int BUSY_CYCLES = 14,
  parameter int BOOT_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PLAYERS-1:0]   req,
  input  logic [4*NUM_PLAYERS-1:0] score_in,
  output logic [NUM_PLAYERS-1:0]   ack,
  output logic [2:0]               trk_playerID,
  output logic [3:0]               trk_newScore,
  output logic                     trk_enable,
  output logic                     busy,
  output logic [2:0]               last_grant,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  localparam int            CNT_MAX   = (BOOT_CYCLES > BUSY_CYCLES) ? BOOT_CYCLES : BUSY_CYCLES;
  localparam int            CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BOOT_LOAD = CW'(BOOT_CYCLES - 1);
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NUM_PLAYERS - 1);

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [2:0]             r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_PLAYERS-1:0] r_ack, w_ack_nxt;
  logic [2:0]             r_pid, w_pid_nxt;
  logic [3:0]             r_score, w_score_nxt;
  logic                   r_enable, w_enable_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [2:0]             r_last, w_last_nxt;

  logic [2*NUM_PLAYERS-1:0] w_req_dbl;
  logic [NUM_PLAYERS-1:0]   w_req_rot;
  logic                     w_found;
  logic [3:0]               w_sum;
  logic [2:0]               w_gnt;
  logic [3:0]               w_gnt_score;
  logic [3:0]               w_clamped;
  logic [NUM_PLAYERS-1:0]   w_ack_onehot;
  logic [2:0]               w_ptr_after;

  // req is exactly NUM_PLAYERS wide, so players at or above NUM_PLAYERS
  // (including tracker address 5, the max-score slot) cannot be requested.
  // Doubling the vector and shifting by rr_ptr puts the highest-priority
  // player at bit 0, so the first set bit is the round-robin winner.
  assign w_req_dbl = {req, req};
  assign w_req_rot = NUM_PLAYERS'(w_req_dbl >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    w_gnt   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + 4'(i);
        if (w_sum >= 4'(NUM_PLAYERS)) w_sum = w_sum - 4'(NUM_PLAYERS);
        w_gnt   = w_sum[2:0];
      end
    end
  end

  always_comb begin
    w_gnt_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (w_gnt == 3'(i)) w_gnt_score = score_in[4*i +: 4];
    end
  end

  // The tracker stores 3-bit scores; anything 8..15 saturates to 7.
  assign w_clamped = w_gnt_score[3] ? 4'd7 : w_gnt_score;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) w_ack_onehot[i] = (r_pid == 3'(i));
  end

  assign w_ptr_after = (r_pid == LAST_IDX) ? 3'd0 : (r_pid + 3'd1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;
    w_ack_nxt    = '0;
    w_pid_nxt    = r_pid;
    w_score_nxt  = r_score;
    w_enable_nxt = 1'b0;
    w_last_nxt   = r_last;
    case (r_state)
      ST_BOOT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      ST_IDLE: begin
        if (w_found) begin
          w_pid_nxt    = w_gnt;
          w_score_nxt  = w_clamped;
          w_enable_nxt = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = BUSY_LOAD;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_ACK;
          w_ack_nxt    = w_ack_onehot;
          w_last_nxt   = r_pid;
          w_rr_ptr_nxt = w_ptr_after;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_BOOT;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_BOOT;
      r_cnt    <= BOOT_LOAD;
      r_rr_ptr <= '0;
      r_ack    <= '0;
      r_pid    <= '0;
      r_score  <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b1;
      r_last   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_ack    <= w_ack_nxt;
      r_pid    <= w_pid_nxt;
      r_score  <= w_score_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign ack          = r_ack;
  assign trk_playerID = r_pid;
  assign trk_newScore = r_score;
  assign trk_enable   = r_enable;
  assign busy         = r_busy;
  assign last_grant   = r_last;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_score_submit_arbiter.sv
// tb_score_submit_arbiter
//   Bench for score_submit_arbiter at default parameters. A transaction-level
//   reference model schedules grants (round-robin over the sampled requests),
//   enable pulses, acks and the busy window from edge counts since reset, and
//   every output is compared against it each cycle.
module tb_score_submit_arbiter;
  localparam int NP      = 5;
  localparam int BUSY    = 14;
  localparam int BOOT    = 8;
  localparam int ACK_OFS = BUSY + 1;
  localparam int PERIOD  = BUSY + 3;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic [4*NP-1:0] score_in;
  logic [NP-1:0] ack;
  logic [2:0]    trk_playerID;
  logic [3:0]    trk_newScore;
  logic          trk_enable;
  logic          busy;
  logic [2:0]    last_grant;
  logic [2:0]    dbg_state;

  score_submit_arbiter #(
    .NUM_PLAYERS(NP),
    .BUSY_CYCLES(BUSY),
    .BOOT_CYCLES(BOOT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .score_in(score_in),
    .ack(ack),
    .trk_playerID(trk_playerID),
    .trk_newScore(trk_newScore),
    .trk_enable(trk_enable),
    .busy(busy),
    .last_grant(last_grant),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [2:0] exp_q[$];
  int         edge_n;
  int         next_free;
  int         g_edge;
  int         g_pid_m;
  int         ptr_m;
  logic [2:0] pid_e;
  logic [3:0] score_e;
  logic [2:0] last_e;
  logic       en_e;
  logic [NP-1:0] ack_e;
  logic       busy_e;

  task automatic model_reset();
    edge_n    = 0;
    next_free = BOOT + 1;
    g_edge    = -1;
    g_pid_m   = 0;
    ptr_m     = 0;
    pid_e     = '0;
    score_e   = '0;
    last_e    = '0;
    en_e      = 1'b0;
    ack_e     = '0;
    busy_e    = 1'b1;
    exp_q.delete();
  endtask

  // Called once per clock edge with req/score_in as they were at that edge.
  task automatic model_edge();
    int g;
    bit granted;
    logic [3:0] sc;
    edge_n++;
    en_e    = 1'b0;
    ack_e   = '0;
    granted = 1'b0;
    g       = 0;
    if (g_edge >= 0 && edge_n == g_edge + ACK_OFS) begin
      ack_e  = NP'(1) << g_pid_m;
      last_e = 3'(g_pid_m);
    end
    if (edge_n >= next_free && req != '0) begin
      for (int k = 0; k < NP; k++) begin
        if (!granted && req[(ptr_m + k) % NP]) begin
          granted = 1'b1;
          g = (ptr_m + k) % NP;
        end
      end
      sc        = score_in[4*g +: 4];
      pid_e     = 3'(g);
      score_e   = (sc > 4'd7) ? 4'd7 : sc;
      en_e      = 1'b1;
      g_edge    = edge_n;
      g_pid_m   = g;
      ptr_m     = (g + 1) % NP;
      next_free = edge_n + PERIOD;
      exp_q.push_back(3'(g));
    end
    busy_e = !(edge_n >= next_free - 1 && !granted);
  endtask

  // ---------------- requester driver ----------------
  logic [NP-1:0] sticky;
  logic [NP-1:0] drop_mask;
  int            p_raise;
  int            p_withdraw;

  task automatic update_stim();
    for (int i = 0; i < NP; i++) begin
      if (ack_e[i]) begin
        if (!sticky[i]) req[i] = 1'b0;
      end else if (en_e && pid_e == 3'(i) && drop_mask[i]) begin
        req[i] = 1'b0;
      end else if (!req[i]) begin
        if (int'($urandom_range(0, 99)) < p_raise) begin
          req[i] = 1'b1;
          score_in[4*i +: 4] = 4'($urandom_range(0, 15));
        end
      end else if (int'($urandom_range(0, 99)) < p_withdraw) begin
        req[i] = 1'b0;
      end
    end
  endtask

  // ---------------- observation ----------------
  int obs_g[$];
  int obs_e[$];
  int obs_s[$];
  int ack_obs[$];
  int ack1_cnt;

  task automatic clear_obs();
    obs_g.delete();
    obs_e.delete();
    obs_s.delete();
    ack_obs.delete();
    ack1_cnt = 0;
  endtask

  task automatic step();
    model_edge();
    check("trk_enable", trk_enable, en_e);
    check("ack", ack, ack_e);
    check("busy", busy, busy_e);
    check("trk_playerID", trk_playerID, pid_e);
    check("trk_newScore", trk_newScore, score_e);
    check("last_grant", last_grant, last_e);
    if (ack != '0) begin
      check("ack_vs_pid", ack, NP'(1) << trk_playerID);
      ack_obs.push_back(edge_n);
      if (ack[1]) ack1_cnt++;
    end
    if (trk_enable) begin
      obs_g.push_back(int'(trk_playerID));
      obs_e.push_back(edge_n);
      obs_s.push_back(int'(trk_newScore));
      if (exp_q.size() > 0) check("grant_order", trk_playerID, exp_q.pop_front());
      else check("grant_unexpected", 1, 0);
    end
    update_stim();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_en"}, trk_enable, 0);
    check({tag, "_pid"}, trk_playerID, 0);
    check({tag, "_score"}, trk_newScore, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_last"}, last_grant, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Holds rst low across one rising edge; the next rising edge is BOOT edge 1.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_now");
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    model_reset();
    rst = 1'b1;
  endtask

  task automatic drain(input int n);
    req     = '0;
    sticky  = '0;
    p_raise = 0;
    run_cycles(n);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst        = 1'b1;
    req        = '0;
    score_in   = '0;
    sticky     = '0;
    drop_mask  = '0;
    p_raise    = 0;
    p_withdraw = 0;
    model_reset();
    clear_obs();
    #2;

    // Single request held through reset.
    req      = 5'b00001;
    score_in = 20'h00005;
    do_reset();
    clear_obs();
    run_cycles(40);
    check("p1_n_grants", obs_g.size(), 1);
    if (obs_g.size() >= 1) begin
      check("p1_grant_edge", obs_e[0], BOOT + 1);
      check("p1_pid", obs_g[0], 0);
      check("p1_score", obs_s[0], 5);
    end
    check("p1_n_acks", ack_obs.size(), 1);
    if (ack_obs.size() >= 1) check("p1_ack_edge", ack_obs[0], BOOT + 1 + ACK_OFS);
    check("p1_last_grant", last_grant, 0);

    // All five together after a fresh reset.
    req      = 5'b11111;
    score_in = 20'h54321;
    do_reset();
    clear_obs();
    run_cycles(100);
    check("p2_n_grants", obs_g.size(), 5);
    for (int i = 0; i < obs_g.size(); i++) begin
      check("p2_order", obs_g[i], i);
      check("p2_score", obs_s[i], i + 1);
      if (i > 0) check("p2_spacing", obs_e[i] - obs_e[i-1], PERIOD);
    end
    check("p2_n_acks", ack_obs.size(), 5);

    // Fairness: players 2 and 4 keep requesting.
    clear_obs();
    score_in = 20'h30600;
    req      = 5'b10100;
    sticky   = 5'b10100;
    run_cycles(90);
    drain(40);
    check("p3_enough_grants", obs_g.size() >= 4, 1);
    if (obs_g.size() >= 1) check("p3_first", obs_g[0], 2);
    for (int i = 1; i < obs_g.size(); i++) check("p3_alternate", obs_g[i] == obs_g[i-1], 0);

    // Clamp: player 3 submits 12.
    clear_obs();
    score_in = 20'h0C000;
    req      = 5'b01000;
    run_cycles(40);
    check("p4_n_grants", obs_g.size(), 1);
    if (obs_g.size() >= 1) begin
      check("p4_pid", obs_g[0], 3);
      check("p4_clamp", obs_s[0], 7);
    end

    // Reset in the middle of HOLD.
    score_in = 20'h0A0B0;
    req      = 5'b01010;
    run_cycles(6);
    do_reset();
    clear_obs();
    run_cycles(50);
    drain(20);
    check("p5_n_grants", obs_g.size(), 2);
    if (obs_g.size() >= 2) begin
      check("p5_first_pid", obs_g[0], 1);
      check("p5_first_edge", obs_e[0], BOOT + 1);
      check("p5_second_pid", obs_g[1], 3);
    end
    if (ack_obs.size() >= 1) check("p5_first_ack_edge", ack_obs[0], BOOT + 1 + ACK_OFS);
    else check("p5_ack_seen", 0, 1);

    // Withdrawn request: player 1 drops req right after its enable.
    clear_obs();
    score_in  = 20'h00040;
    req       = 5'b00010;
    drop_mask = 5'b00010;
    run_cycles(40);
    drop_mask = '0;
    check("p6_n_grants", obs_g.size(), 1);
    if (obs_g.size() >= 1) check("p6_pid", obs_g[0], 1);
    check("p6_ack1_count", ack1_cnt, 1);

    // Randomized traffic with one reset in the middle.
    p_withdraw = 1;
    for (int b = 0; b < 4; b++) begin
      p_raise = int'($urandom_range(5, 30));
      sticky  = NP'($urandom_range(0, 31));
      if (b == 2) do_reset();
      run_cycles(350);
    end
    p_withdraw = 0;
    drain(40);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
